// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared widths and state/requester types for cache_arbiter
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - grants the I-cache or D-cache one line transaction at a time on the adaptor port
// CACHE_ARB_RR_EN selects round-robin tie breaking; undefined gives fixed D-over-I priority.
module cache_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t r_state;

  logic w_i_pend;
  logic w_d_pend;
  logic w_tie_to_d;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_pend = i_read;
  assign w_d_pend = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
  req_id_t r_last_grant;

  // The requester that did not win last time takes the tie.
  assign w_tie_to_d = (r_last_grant == REQ_I);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ_I;
    end else if (r_state == ARB_IDLE) begin
      if (w_grant_d) begin
        r_last_grant <= REQ_D;
      end else if (w_grant_i) begin
        r_last_grant <= REQ_I;
      end
    end
  end
`else
  assign w_tie_to_d = 1'b1;
`endif

  assign w_grant_d = w_d_pend & (~w_i_pend | w_tie_to_d);
  assign w_grant_i = w_i_pend & ~w_grant_d;

  // Every grant returns through ARB_IDLE so the adaptor sees a command-free cycle between transactions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_state <= ARB_D;
          end else if (w_grant_i) begin
            r_state <= ARB_I;
          end
        end
        ARB_I: begin
          if (mem_resp) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_D: begin
          if (mem_resp) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      ARB_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_resp      = mem_resp;
      end
      ARB_D: begin
        mem_write   = d_write;
        mem_read    = d_read & ~d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_resp      = mem_resp;
      end
      default: begin
      end
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter with a fixed-latency adaptor model
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  typedef struct packed {
    logic [1:0]        resps;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } exp_t;

  localparam logic [31:0] INC = 32'h1111_1111;

  logic              clk;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  int                lat = 6;
  int                cnt = 0;
  logic [31:0]       resp_word = 32'h0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic              cap_wr = 1'b0;

  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // One cycle: advance past the edge, run the adaptor model, let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      cnt = 0;
      mem_resp = 1'b0;
    end else if (mem_resp) begin
      mem_resp = 1'b0;
      cnt = 0;
      resp_word = resp_word + INC;
    end else if (mem_read || mem_write) begin
      if (cnt == 0) begin
        cap_addr = mem_address;
        cap_wr   = mem_write;
      end
      cnt++;
      if (cnt >= lat) begin
        mem_resp  = 1'b1;
        mem_rdata = {8{resp_word}};
      end
    end
    #1;
  endtask

  task automatic wait_resp(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      got = i_resp | d_resp;
    end
  endtask

  function automatic exp_t observe();
    return exp_t'({i_resp, d_resp, cap_wr, cap_addr, (i_resp ? i_rdata : d_rdata)});
  endfunction

  function automatic exp_t mk(input logic [1:0] r, input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [31:0] w);
    return exp_t'({r, wr, a, {8{w}}});
  endfunction

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return '0;
    return sb.pop_front();
  endfunction

  task automatic apply_reset();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();
    step();
    n_cmp++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    n_cmp++;
    if (mem_address !== '0) begin
      n_err++;
      $display("FAIL reset_addr: got %h want 0", mem_address);
    end
    n_cmp++;
    if (mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_wdata: got %h want 0", mem_wdata);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({mem_read, mem_write} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 00", {mem_read, mem_write});
    end
  endtask

  task automatic test_i_read();
    bit got;
    exp_t e, o;
    resp_word = 32'hA5A5_A5A5;
    i_address = 32'h0000_1000;
    sb.push_back(mk(2'b10, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5));
    i_read = 1'b1;
    step();
    n_cmp++;
    if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      n_err++;
      $display("FAIL i_grant: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=00001000",
               mem_read, mem_write, mem_address);
    end
    wait_resp(20, got);
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL i_read_resp: got %h (seen=%0b) want %h", o, got, e);
    end
    i_read = 1'b0;
    step();
    n_cmp++;
    if ({i_resp, d_resp, mem_read} !== 3'b000) begin
      n_err++;
      $display("FAIL i_resp_pulse: got %b want 000", {i_resp, d_resp, mem_read});
    end
  endtask

  task automatic test_d_write();
    bit got, bad;
    exp_t e, o;
    resp_word = 32'h0BAD_F00D;
    d_address = 32'h0000_2000;
    d_wdata   = {8{32'h1234_5678}};
    sb.push_back(mk(2'b01, 1'b1, 32'h0000_2000, 32'h0BAD_F00D));
    d_write = 1'b1;
    got = 1'b0; bad = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = i_resp | d_resp;
      if (!(mem_write && !mem_read && mem_wdata == d_wdata && mem_address == d_address)) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL d_write_cmd: got rd=%b wr=%b wdata=%h want rd=0 wr=1 wdata=%h",
               mem_read, mem_write, mem_wdata, d_wdata);
    end
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL d_write_resp: got %h (seen=%0b) want %h", o, got, e);
    end
    d_write = 1'b0;
    step();
    n_cmp++;
    if ({d_resp, i_resp, mem_write, mem_read} !== 4'b0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL d_write_idle: got ctrl=%b wdata=%h want ctrl=0000 wdata=0",
               {d_resp, i_resp, mem_write, mem_read}, mem_wdata);
    end
    step();
  endtask

  task automatic test_grant_hold();
    bit got;
    exp_t e, o;
    resp_word = 32'h3C3C_0001;
    i_address = 32'h0000_3000;
    sb.push_back(mk(2'b10, 1'b0, 32'h0000_3000, 32'h3C3C_0001));
    i_read = 1'b1;
    step();
    i_read = 1'b0;
    wait_resp(20, got);
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL grant_hold: got %h (seen=%0b) want %h", o, got, e);
    end
    step();
  endtask

  task automatic test_tie();
    bit got;
    exp_t e, o;
    apply_reset();
    resp_word = 32'h7000_0000;
    i_address = 32'h0000_4000;
    d_address = 32'h0000_5000;
    sb.push_back(mk(2'b01, 1'b0, 32'h0000_5000, 32'h7000_0000));
    sb.push_back(mk(2'b10, 1'b0, 32'h0000_4000, 32'h7000_0000 + INC));
    i_read = 1'b1; d_read = 1'b1;
    step();
    n_cmp++;
    if ({mem_read, mem_address} !== {1'b1, 32'h0000_5000}) begin
      n_err++;
      $display("FAIL tie_first: got rd=%b addr=%h want rd=1 addr=00005000", mem_read, mem_address);
    end
    wait_resp(20, got);
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL tie_d_resp: got %h (seen=%0b) want %h", o, got, e);
    end
    d_read = 1'b0;
    step();
    n_cmp++;
    if (mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL tie_gap: got rd=%b want rd=0", mem_read);
    end
    step();
    n_cmp++;
    if ({mem_read, mem_address} !== {1'b1, 32'h0000_4000}) begin
      n_err++;
      $display("FAIL tie_second: got rd=%b addr=%h want rd=1 addr=00004000", mem_read, mem_address);
    end
    wait_resp(20, got);
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL tie_i_resp: got %h (seen=%0b) want %h", o, got, e);
    end
    i_read = 1'b0;
    step();
  endtask

  task automatic test_continuous();
    bit got;
    exp_t e, o;
    apply_reset();
    resp_word = 32'h0100_0000;
    i_address = 32'h0000_A000;
    d_address = 32'h0000_B000;
    sb.push_back(mk(2'b01, 1'b0, 32'h0000_B000, 32'h0100_0000));
`ifdef CACHE_ARB_RR_EN
    sb.push_back(mk(2'b10, 1'b0, 32'h0000_A000, 32'h0100_0000 + INC));
`else
    sb.push_back(mk(2'b01, 1'b0, 32'h0000_B000, 32'h0100_0000 + INC));
`endif
    sb.push_back(mk(2'b01, 1'b0, 32'h0000_B000, 32'h0100_0000 + 2 * INC));
    i_read = 1'b1; d_read = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_resp(40, got);
      o = observe(); e = pop_exp(); n_cmp++;
      if (!got || o !== e) begin
        n_err++;
        $display("FAIL continuous_%0d: got %h (seen=%0b) want %h", t, o, got, e);
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    bit got;
    exp_t e, o;
    lat = 6;
    d_address = 32'h0000_6000;
    d_read = 1'b1;
    step(); step(); step();
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: got rd=%b want rd=1", mem_read);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_address !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got ctrl=%b addr=%h want ctrl=0000 addr=0",
               {mem_read, mem_write, i_resp, d_resp}, mem_address);
    end
    reset = 1'b0; d_read = 1'b0;
    step();
    n_cmp++;
    if ({mem_read, mem_write, d_resp} !== 3'b0) begin
      n_err++;
      $display("FAIL mid_after: got %b want 000", {mem_read, mem_write, d_resp});
    end
    resp_word = 32'h5EED_0000;
    i_address = 32'h0000_7000;
    sb.push_back(mk(2'b10, 1'b0, 32'h0000_7000, 32'h5EED_0000));
    i_read = 1'b1;
    step();
    n_cmp++;
    if ({mem_read, mem_address} !== {1'b1, 32'h0000_7000}) begin
      n_err++;
      $display("FAIL mid_regrant: got rd=%b addr=%h want rd=1 addr=00007000", mem_read, mem_address);
    end
    wait_resp(20, got);
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL mid_i_resp: got %h (seen=%0b) want %h", o, got, e);
    end
    i_read = 1'b0;
    step();
  endtask

  task automatic test_rw_both_spurious();
    bit got;
    exp_t e, o;
    resp_word = 32'hCAFE_0000;
    d_address = 32'h0000_8000;
    d_wdata   = {8{32'hDEAD_BEEF}};
    sb.push_back(mk(2'b01, 1'b1, 32'h0000_8000, 32'hCAFE_0000));
    d_read = 1'b1; d_write = 1'b1;
    step();
    n_cmp++;
    if ({mem_read, mem_write} !== 2'b01) begin
      n_err++;
      $display("FAIL rw_both: got rd=%b wr=%b want rd=0 wr=1", mem_read, mem_write);
    end
    wait_resp(20, got);
    o = observe(); e = pop_exp(); n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL rw_both_resp: got %h (seen=%0b) want %h", o, got, e);
    end
    d_read = 1'b0; d_write = 1'b0;
    step();
    step();
    mem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b00) begin
      n_err++;
      $display("FAIL spurious_resp: got i=%b d=%b want i=0 d=0", i_resp, d_resp);
    end
    step();
    n_cmp++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
      n_err++;
      $display("FAIL spurious_after: got %b want 0000", {mem_read, mem_write, i_resp, d_resp});
    end
  endtask

  initial begin
    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;

    test_reset();
    test_i_read();
    test_d_write();
    test_grant_hold();
    test_tie();
    test_continuous();
    test_reset_mid();
    test_rw_both_spurious();

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates two L1 caches over the single 256-bit line port of the cacheline adaptor. The instruction cache is read-only; the data cache reads and writes back. The block sits between the split L1 caches and the adaptor. It grants one requester per transaction, muxes address, data and commands to the adaptor, and routes the response back to the granted requester only.

## Interface
- ADDR_W, 32, address width
- LINE_W, 256, cache line width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache, valid with i_resp
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, level
- d_write  in  1  D-cache writeback request, level
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache, valid with d_resp
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  read command to adaptor
- mem_write  out  1  write command to adaptor
- mem_address  out  ADDR_W  address to adaptor
- mem_wdata  out  LINE_W  writeback line to adaptor
- mem_rdata  in  LINE_W  line from adaptor
- mem_resp  in  1  one-cycle completion pulse from adaptor

## Operation
- States: ARB_IDLE, ARB_I, ARB_D. Reset enters ARB_IDLE.
- ARB_IDLE:
  - Only i pending -> ARB_I.
  - Only d (d_read or d_write) pending -> ARB_D.
  - Both pending -> tie rule (see Configuration).
  - Nothing pending -> stay.
- ARB_I:
  - mem_read=1, mem_address=i_address.
  - i_resp=mem_resp.
  - On mem_resp -> ARB_IDLE.
- ARB_D:
  - mem_write=d_write.
  - mem_read=d_read & ~d_write, so write wins if both are high.
  - mem_address=d_address, mem_wdata=d_wdata.
  - d_resp=mem_resp.
  - On mem_resp -> ARB_IDLE.
- Command outputs are decoded combinationally from the registered state. In ARB_IDLE: mem_read=mem_write=0, mem_address=0, mem_wdata=0.
- i_rdata and d_rdata are direct passthrough of mem_rdata. They are meaningful only with the matching resp.
- A non-granted requester never sees a resp. mem_resp arriving in ARB_IDLE is ignored.
- A grant is held until mem_resp, even if the requester drops its request.
- The mandatory ARB_IDLE cycle after each response guarantees the adaptor returns to idle before the next command is seen, so a stale request cannot retrigger the adaptor.
- Reset mid-transaction: state -> ARB_IDLE and all commands drop next edge. The adaptor and the caches are reset by the same signal.

## Timing
- Request first high at cycle N (arbiter in ARB_IDLE): grant state at N+1, mem_read/mem_write high from N+1.
- The adaptor's mem_resp at cycle M is forwarded combinationally to the granted requester in cycle M.
- Arbiter is back in ARB_IDLE at M+1. A pending other requester is granted at M+2.
- Arbiter overhead: 1 cycle before each transaction plus 1 idle cycle after it.
- Reset values: state ARB_IDLE; mem_read, mem_write, i_resp, d_resp, mem_address, mem_wdata all 0; last-grant register = I.

## Configuration
- CACHE_ARB_RR_EN defined:
  - Ties go round-robin; the requester not granted last wins.
  - last_grant updates on each grant; reset value I, so the first tie goes to D.
- CACHE_ARB_RR_EN undefined:
  - Fixed priority, D always wins ties.
  - last_grant is not implemented.
  - I may starve under continuous D traffic; this is accepted.

## Structure
- Package cache_arb_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_I, ARB_D};
  - enum req_id_t {REQ_I, REQ_D};
  - localparams ADDR_W=32, LINE_W=256.
- Single module; no sub-module is warranted. The tie logic is a few lines of combinational code.

## Test plan
- i_read=1, i_address=0x0000_1000, adaptor model returns 0xA5..A5 after 6 cycles -> mem_read=1 and mem_address=0x1000 one cycle after the request; i_rdata=0xA5..A5 with a one-cycle i_resp; d_resp stays 0.
- d_write=1, d_address=0x2000, d_wdata=0x1234..:
  - mem_write=1, mem_read=0, mem_wdata=0x1234.. for the whole grant;
  - d_resp pulses once;
  - one ARB_IDLE cycle follows.
- i_read and d_read rise in the same cycle:
  - RR build: D served first, then I granted 2 cycles after D's resp.
  - Fixed build: D first.
- Continuous d_read with i_read held, RR build -> grants alternate D, I, D. Fixed build -> I never granted over 3 D transactions.
- Reset asserted during ARB_D before mem_resp -> next cycle mem_read=mem_write=0, no d_resp, state ARB_IDLE. A new i_read is granted normally afterward.
- d_read and d_write both high -> mem_write=1, mem_read=0. A spurious mem_resp in ARB_IDLE produces no i_resp or d_resp.
